// File: rtl/adc_qsys_mem_arb_pkg.sv
// Purpose: shared types and default sizes for the two-requester RAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adc_qsys_mem_arb_pkg;

    // Requester identity: m0 is the ADC capture path, m1 is the CPU.
    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } req_id_t;

    localparam int ADDR_W_DFLT = 2;
    localparam int DATA_W_DFLT = 32;
    localparam int BE_W_DFLT   = DATA_W_DFLT / 8;

endpackage

// File: rtl/adc_qsys_arb2_grant.sv
// Purpose: two-way grant decision (round-robin when ADC_QSYS_MEM_ARB_RR_EN, else m0 fixed priority).
// Latency: combinational, zero cycles.
// Backpressure: a requester that loses contention gets no grant and must hold its request.
module adc_qsys_arb2_grant
    import adc_qsys_mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant,
    output logic       grant_id
);

`ifndef ADC_QSYS_MEM_ARB_RR_EN
    // Fixed priority keeps the priority register in the design but out of the decision.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    // Pick at most one requester; contention resolved by the configured policy.
    always_comb begin
        grant    = 2'b00;
        grant_id = M0;
        case (req)
            2'b01: begin
                grant    = 2'b01;
                grant_id = M0;
            end
            2'b10: begin
                grant    = 2'b10;
                grant_id = M1;
            end
            2'b11: begin
`ifdef ADC_QSYS_MEM_ARB_RR_EN
                if (last_grant == M0) begin
                    grant    = 2'b10;
                    grant_id = M1;
                end else begin
                    grant    = 2'b01;
                    grant_id = M0;
                end
`else
                grant    = 2'b01;
                grant_id = M0;
`endif
            end
            default: begin
                grant    = 2'b00;
                grant_id = M0;
            end
        endcase
    end

endmodule

// File: rtl/adc_qsys_mem_arbiter.sv
// Purpose: share one 1-cycle-latency RAM port between ADC capture (m0) and CPU (m1); ADC_QSYS_MEM_ARB_RR_EN selects round-robin.
// Latency: request granted same cycle; readdatavalid exactly one cycle after an accepted read.
// Backpressure: losing requester sees waitrequest=1 and holds its request; both stalled during reset.
module adc_qsys_mem_arbiter
    import adc_qsys_mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DFLT,
    parameter int DATA_W = DATA_W_DFLT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     m0_address,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic [DATA_W-1:0]     m0_writedata,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,
    input  logic [ADDR_W-1:0]     m1_address,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic [DATA_W-1:0]     m1_writedata,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    input  logic [DATA_W-1:0]     mem_readdata
);

    localparam int BE_W = DATA_W / 8;

    logic [1:0]        req;
    logic [1:0]        grant;
    logic              grant_id;
    logic              gnt_any;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_address;
    logic [BE_W-1:0]   sel_byteenable;
    logic [DATA_W-1:0] sel_writedata;

    logic              last_grant;
    logic              rd_pend;
    req_id_t           rd_owner;
    logic [ADDR_W-1:0] hold_address;
    logic [BE_W-1:0]   hold_byteenable;
    logic [DATA_W-1:0] hold_writedata;

    // Nobody is granted while reset is high, so the RAM port stays quiet.
    assign req = reset ? 2'b00 : {m1_read | m1_write, m0_read | m0_write};

    adc_qsys_arb2_grant u_grant (
        .req        (req),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_id   (grant_id)
    );

    assign gnt_any        = |grant;
    assign sel_write      = (grant_id == M1) ? m1_write      : m0_write;
    assign sel_address    = (grant_id == M1) ? m1_address    : m0_address;
    assign sel_byteenable = (grant_id == M1) ? m1_byteenable : m0_byteenable;
    assign sel_writedata  = (grant_id == M1) ? m1_writedata  : m0_writedata;

    // Idle cycles replay the last driven address/lanes/data to avoid toggling the RAM bus.
    assign mem_chipselect = gnt_any;
    assign mem_write      = gnt_any & sel_write;
    assign mem_address    = gnt_any ? sel_address    : hold_address;
    assign mem_byteenable = gnt_any ? sel_byteenable : hold_byteenable;
    assign mem_writedata  = gnt_any ? sel_writedata  : hold_writedata;

    assign m0_waitrequest = reset | (req[0] & ~grant[0]);
    assign m1_waitrequest = reset | (req[1] & ~grant[1]);

    // Return data is steered to the read owner only; the other side sees zero.
    assign m0_readdatavalid = rd_pend & (rd_owner == M0);
    assign m1_readdatavalid = rd_pend & (rd_owner == M1);
    assign m0_readdata      = m0_readdatavalid ? mem_readdata : '0;
    assign m1_readdata      = m1_readdatavalid ? mem_readdata : '0;

    // Track the one-deep read pipeline, priority state and the held RAM bus values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend         <= 1'b0;
            rd_owner        <= M0;
            last_grant      <= M1;
            hold_address    <= '0;
            hold_byteenable <= '0;
            hold_writedata  <= '0;
        end else begin
            rd_pend <= gnt_any & ~sel_write;
            if (gnt_any) begin
                rd_owner        <= req_id_t'(grant_id);
                last_grant      <= grant_id;
                hold_address    <= sel_address;
                hold_byteenable <= sel_byteenable;
                hold_writedata  <= sel_writedata;
            end
        end
    end

endmodule

// File: tb/tb_adc_qsys_mem_arbiter.sv
module tb_adc_qsys_mem_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  m0_address, m1_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [1:0]  mem_address;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic        mem_chipselect, mem_write;
    logic [31:0] mem_readdata;

    typedef struct {
        logic        owner;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] ram [4];

    adc_qsys_mem_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .m0_address       (m0_address),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_byteenable    (m0_byteenable),
        .m0_writedata     (m0_writedata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_byteenable    (m1_byteenable),
        .m1_writedata     (m1_writedata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_writedata    (mem_writedata),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_readdata     (mem_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM behavioural model: byte-lane writes, registered read output.
    initial begin
        for (int i = 0; i < 4; i++) ram[i] = 32'h0;
        mem_readdata = 32'h0;
    end
    always @(posedge clk) begin
        if (mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic owner, input logic [31:0] data);
        exp_t e;
        e.owner = owner;
        e.data  = data;
        e.cyc   = cyc + 1;
        sb.push_back(e);
    endtask

    // Monitor: every readdatavalid pops one expected read and compares owner, data, cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (m0_readdatavalid && m1_readdatavalid) begin
                total++;
                bad++;
                $display("FAIL dual_valid actual=both required=one (t=%0t)", $time);
            end else if (m0_readdatavalid || m1_readdatavalid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid actual=m%0d valid required=none (t=%0t)",
                             m1_readdatavalid, $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rd_owner", {31'b0, m1_readdatavalid}, {31'b0, e.owner});
                    chk("rd_data", m1_readdatavalid ? m1_readdata : m0_readdata, e.data);
                    chk("rd_cycle", cyc, e.cyc);
                    chk("rd_nonowner_zero", m1_readdatavalid ? m0_readdata : m1_readdata, 32'h0);
                end
            end
        end
    end

    task automatic idle();
        @(posedge clk); #1;
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    endtask

    task automatic m1_do(input logic wr, input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
        @(posedge clk); #1;
        m1_write = wr; m1_read = !wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic g;
        reset = 1;
        m0_read = 0; m0_write = 0; m0_address = 0; m0_byteenable = 0; m0_writedata = 0;
        m1_read = 0; m1_write = 0; m1_address = 0; m1_byteenable = 0; m1_writedata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_m0_wait", {31'b0, m0_waitrequest}, 32'h1);
        chk("rst_m1_wait", {31'b0, m1_waitrequest}, 32'h1);
        chk("rst_cs", {31'b0, mem_chipselect}, 32'h0);
        chk("rst_wr", {31'b0, mem_write}, 32'h0);
        chk("rst_addr", {30'b0, mem_address}, 32'h0);
        chk("rst_rdv", {30'b0, m1_readdatavalid, m0_readdatavalid}, 32'h0);
        @(posedge clk); #1;
        reset = 0;

        // m0 write, m1 idle: zero-latency grant
        m0_write = 1; m0_address = 2; m0_byteenable = 4'hF; m0_writedata = 32'hDEADBEEF;
        @(negedge clk);
        chk("t1_m0_wait", {31'b0, m0_waitrequest}, 32'h0);
        chk("t1_mem_write", {31'b0, mem_write}, 32'h1);
        chk("t1_mem_addr", {30'b0, mem_address}, 32'h2);
        chk("t1_mem_wdata", mem_writedata, 32'hDEADBEEF);

        // m1 reads back the same address next cycle
        @(posedge clk); #1;
        m0_write = 0; m1_read = 1; m1_address = 2; m1_byteenable = 4'hF;
        push(1'b1, 32'hDEADBEEF);
        @(negedge clk);
        chk("t2_m1_wait", {31'b0, m1_waitrequest}, 32'h0);
        chk("t2_mem_write", {31'b0, mem_write}, 32'h0);
        idle();
        @(negedge clk);
        chk("t2_m1_rdv", {31'b0, m1_readdatavalid}, 32'h1);
        chk("t2_m0_rdv", {31'b0, m0_readdatavalid}, 32'h0);
        chk("idle_cs", {31'b0, mem_chipselect}, 32'h0);
        chk("idle_addr_hold", {30'b0, mem_address}, 32'h2);

        // preload other words through m1
        m1_do(1, 0, 4'hF, 32'h11110000);
        m1_do(1, 1, 4'hF, 32'h22221111);
        m1_do(1, 3, 4'hF, 32'h44443333);

        // both read every cycle; last grant was m1
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            m1_write = 0;
            m0_read = 1; m0_address = 0;
            m1_read = 1; m1_address = 3;
`ifdef ADC_QSYS_MEM_ARB_RR_EN
            g = (i % 2) != 0;
`else
            g = 1'b0;
`endif
            push(g, g ? 32'h44443333 : 32'h11110000);
            @(negedge clk);
            chk("t3_m0_wait", {31'b0, m0_waitrequest}, {31'b0, g});
            chk("t3_m1_wait", {31'b0, m1_waitrequest}, {31'b0, !g});
            chk("t3_mem_addr", {30'b0, mem_address}, g ? 32'h3 : 32'h0);
        end
        @(posedge clk); #1;
        m0_read = 0;
        push(1'b1, 32'h44443333);
        @(negedge clk);
        chk("t3_m1_alone_wait", {31'b0, m1_waitrequest}, 32'h0);
        idle();

        // partial-lane write then read
        m1_do(1, 2, 4'h3, 32'h00001234);
        @(negedge clk);
        chk("t4_mem_be", {28'b0, mem_byteenable}, 32'h3);
        m1_do(0, 2, 4'hF, 32'h0);
        push(1'b1, 32'hDEAD1234);
        idle();

        // reset with an m0 read in flight
        @(posedge clk); #1;
        m0_read = 1; m0_address = 1;
        @(negedge clk);
        chk("t5_m0_wait", {31'b0, m0_waitrequest}, 32'h0);
        @(posedge clk); #1;
        reset = 1;
        @(negedge clk);
        chk("t5_rst_cs", {31'b0, mem_chipselect}, 32'h0);
        chk("t5_rst_m0_wait", {31'b0, m0_waitrequest}, 32'h1);
        chk("t5_rst_m1_wait", {31'b0, m1_waitrequest}, 32'h1);
        chk("t5_rst_m0_rdv", {31'b0, m0_readdatavalid}, 32'h0);
        @(posedge clk); #1;
        reset = 0; m0_read = 0;
        @(negedge clk);
        chk("t5_post_m0_rdv", {31'b0, m0_readdatavalid}, 32'h0);
        idle();

        // simultaneous m0 write / m1 read of addr 1 after reset
        @(posedge clk); #1;
        m0_write = 1; m0_address = 1; m0_byteenable = 4'hF; m0_writedata = 32'hCAFEF00D;
        m1_read = 1; m1_address = 1; m1_byteenable = 4'hF;
        @(negedge clk);
        chk("t6_m0_wait", {31'b0, m0_waitrequest}, 32'h0);
        chk("t6_m1_wait", {31'b0, m1_waitrequest}, 32'h1);
        chk("t6_mem_write", {31'b0, mem_write}, 32'h1);
        chk("t6_mem_addr", {30'b0, mem_address}, 32'h1);
        @(posedge clk); #1;
        m0_write = 0;
        push(1'b1, 32'hCAFEF00D);
        @(negedge clk);
        chk("t6_m1_wait2", {31'b0, m1_waitrequest}, 32'h0);
        chk("t6_mem_write2", {31'b0, mem_write}, 32'h0);
        idle();
        repeat (3) idle();
        @(negedge clk);
        chk("sb_drained", sb.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_qsys_mem_arbiter.md
ADC_QSYS_MEM_ARBITER -- requirements
Module: adc_qsys_mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 2, word address width of shared RAM (4 words).
REQ-002 Parameter: DATA_W, 32, data width; byteenable width is DATA_W/8.
REQ-003 Port: clk  in  1  single clock; all state on rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: m0_address / m1_address  in  ADDR_W  requester word address (m0 = ADC capture, m1 = CPU).
REQ-006 Port: m0_read, m0_write / m1_read, m1_write  in  1 each  Avalon-MM read/write request.
REQ-007 Port: m0_byteenable / m1_byteenable  in  DATA_W/8  byte lanes for write.
REQ-008 Port: m0_writedata / m1_writedata  in  DATA_W  write data.
REQ-009 Port: m0_waitrequest / m1_waitrequest  out  1  request not accepted this cycle.
REQ-010 Port: m0_readdata / m1_readdata  out  DATA_W  read return data.
REQ-011 Port: m0_readdatavalid / m1_readdatavalid  out  1  readdata valid this cycle.
REQ-012 Port: mem_address  out  ADDR_W; mem_byteenable  out  DATA_W/8; mem_writedata  out  DATA_W; mem_chipselect, mem_write  out  1 each -- shared RAM port.
REQ-013 Port: mem_readdata  in  DATA_W  RAM output, valid one cycle after address accepted.

Function
REQ-014 A request is a cycle with mX_read or mX_write high; read and write together from one requester SHALL be treated as write.
REQ-015 At most one request SHALL be granted per cycle; grant is combinational from current requests and priority state.
REQ-016 Granted requester's address, byteenable, writedata SHALL drive mem_*; mem_chipselect=1, mem_write=granted write.
REQ-017 Granted requester's waitrequest SHALL be 0; a requesting, non-granted requester's waitrequest SHALL be 1; a non-requesting requester's waitrequest SHALL be 0.
REQ-018 Requesters SHALL hold request signals stable while waitrequest=1 (Avalon rule); arbiter need not latch them.
REQ-019 Single requester SHALL be granted in the same cycle (zero added latency).
REQ-020 Granted read SHALL set rd_pend=1 and rd_owner=grantee on the clock edge; next cycle the owner's readdatavalid=1 and readdata=mem_readdata (read latency exactly 1).
REQ-021 Back-to-back reads (including alternating owners) SHALL be accepted every cycle; readdatavalid SHALL follow each accepted read by exactly one cycle, in order.
REQ-022 Write to address A followed next cycle by read of A SHALL return the newly written data.
REQ-023 Idle cycle: mem_chipselect=0, mem_write=0, mem_address/byteenable/writedata hold last driven value.
REQ-024 Non-owner readdata SHALL be 0; readdatavalid never asserted for both requesters in one cycle.
REQ-025 Priority state last_grant (1 bit) SHALL update only on cycles with a grant.

Reset
REQ-026 During/after reset: rd_pend=0, last_grant=1 (m0 wins first contention), both readdatavalid=0, mem_chipselect=0, mem_write=0, mem_address=0.
REQ-027 Reset asserted with a read in flight SHALL discard it; no readdatavalid after reset release.
REQ-028 While reset is high, both waitrequest SHALL be 1.

Configuration
REQ-029 Macro ADC_QSYS_MEM_ARB_RR_EN defined: on contention, grant requester not equal to last_grant (round-robin); each contending requester granted within 2 cycles.
REQ-030 Macro undefined: fixed priority, m0 always wins contention; last_grant register still present but unused for decision.

Structure
REQ-031 Shared package adc_qsys_mem_arb_pkg SHALL hold the requester-id type (M0=0, M1=1), ADDR_W/DATA_W defaults, and byteenable width constant.
REQ-032 Grant logic SHALL be one sub-module adc_qsys_arb2_grant (req[1:0], last_grant -> grant[1:0], grant_id); remainder in adc_qsys_mem_arbiter.

Verification
REQ-033 m0 writes 0xDEADBEEF to addr 2, be=0xF, m1 idle -> m0_waitrequest=0 same cycle, mem_write=1, mem_address=2.
REQ-034 m1 read addr 2 next cycle -> one cycle later m1_readdatavalid=1, m1_readdata=0xDEADBEEF, m0_readdatavalid=0.
REQ-035 Both read every cycle for 4 cycles, RR_EN defined -> grants alternate m0,m1,m0,m1; each valid 1 cycle after its grant; without macro -> m0 granted all 4, m1_waitrequest=1 throughout.
REQ-036 m1 write be=0x3 data 0x0000_1234 to addr 2 holding 0xDEADBEEF, then read -> 0xDEAD1234.
REQ-037 Reset asserted cycle after m0 read grant -> no m0_readdatavalid afterward; mem_chipselect=0, both waitrequest=1 while reset high.
REQ-038 Simultaneous m0 write/m1 read of addr 1 after reset (RR_EN) -> m0 write first, m1 read next cycle returns m0 data.
